// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the FD/X/MW pipeline control slice.
// Contents: RV32I major opcodes, pc_sel mux encodings and the hazard FSM states.
package riscv_ctrl_pkg;

   localparam logic [6:0] OPC_R     = 7'h33;
   localparam logic [6:0] OPC_I     = 7'h13;
   localparam logic [6:0] OPC_LOAD  = 7'h03;
   localparam logic [6:0] OPC_STORE = 7'h23;
   localparam logic [6:0] OPC_BR    = 7'h63;
   localparam logic [6:0] OPC_JAL   = 7'h6F;
   localparam logic [6:0] OPC_JALR  = 7'h67;
   localparam logic [6:0] OPC_LUI   = 7'h37;
   localparam logic [6:0] OPC_AUIPC = 7'h17;
   localparam logic [6:0] OPC_CSR   = 7'h73;

   localparam logic [1:0] PC_FD_TGT  = 2'd0;
   localparam logic [1:0] PC_ALU     = 2'd1;
   localparam logic [1:0] PC_PLUS4   = 2'd2;
   localparam logic [1:0] PC_X_PLUS4 = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_MEM_WAIT = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/inst_class_dec.sv
// Opcode classifier used once per pipeline stage.
// Ports: opcode_i (7b major opcode) -> writes_rd_o, reads_rs1_o, reads_rs2_o,
//        is_branch_o, is_mem_o (1b class flags).
module inst_class_dec
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic       writes_rd_o,
   output logic       reads_rs1_o,
   output logic       reads_rs2_o,
   output logic       is_branch_o,
   output logic       is_mem_o
);

   always_comb begin
      writes_rd_o = 1'b0;
      reads_rs1_o = 1'b0;
      reads_rs2_o = 1'b0;
      is_branch_o = 1'b0;
      is_mem_o    = 1'b0;
      case (opcode_i)
         OPC_R:     begin writes_rd_o = 1'b1; reads_rs1_o = 1'b1; reads_rs2_o = 1'b1; end
         OPC_I:     begin writes_rd_o = 1'b1; reads_rs1_o = 1'b1; end
         OPC_LOAD:  begin writes_rd_o = 1'b1; reads_rs1_o = 1'b1; is_mem_o = 1'b1; end
         OPC_STORE: begin reads_rs1_o = 1'b1; reads_rs2_o = 1'b1; is_mem_o = 1'b1; end
         OPC_BR:    begin reads_rs1_o = 1'b1; reads_rs2_o = 1'b1; is_branch_o = 1'b1; end
         OPC_JAL:   writes_rd_o = 1'b1;
         OPC_JALR:  begin writes_rd_o = 1'b1; reads_rs1_o = 1'b1; end
         OPC_LUI:   writes_rd_o = 1'b1;
         OPC_AUIPC: writes_rd_o = 1'b1;
         default:   ;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller for the 3-stage FD/X/MW RV32I core: memory stalls,
// static branch prediction with recovery, redirect bubbles, forwarding and
// saturating performance counters.
// Ports: inst_fd/inst_x/inst_mw (32b stage instructions), breq/brlt (X compare),
//        dmem_ack (MW access done) -> pc_sel, stall, flush_fd, flush_x, brun,
//        asel, bsel, wb2d_a, wb2d_b, cnt_stall/cnt_flush/cnt_mispred (CNT_W).
module hazard_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int unsigned FETCH_LAT        = 1,
   parameter bit          PREDICT_BACKWARD = 1'b1,
   parameter int unsigned CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      inst_fd,
   input  logic [31:0]      inst_x,
   input  logic [31:0]      inst_mw,
   input  logic             breq,
   input  logic             brlt,
   input  logic             dmem_ack,
   output logic [1:0]       pc_sel,
   output logic             stall,
   output logic             flush_fd,
   output logic             flush_x,
   output logic             brun,
   output logic [1:0]       asel,
   output logic [1:0]       bsel,
   output logic             wb2d_a,
   output logic             wb2d_b,
   output logic [CNT_W-1:0] cnt_stall,
   output logic [CNT_W-1:0] cnt_flush,
   output logic [CNT_W-1:0] cnt_mispred
);

   localparam logic [2:0] RCNT_INIT = 3'(FETCH_LAT - 1);

   ctrl_state_e      state_q, state_d, ret_q, ret_d, eff_state;
   logic             pred_x_q, pred_x_d;
   logic [2:0]       rcnt_q, rcnt_d;
   logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q, cnt_mispred_q;

   logic fd_wr, fd_rs1, fd_rs2, fd_br, fd_mem;
   logic x_wr, x_rs1, x_rs2, x_br, x_mem;
   logic mw_wr, mw_rs1, mw_rs2, mw_br, mw_mem;

   inst_class_dec u_dec_fd (.opcode_i(inst_fd[6:0]), .writes_rd_o(fd_wr), .reads_rs1_o(fd_rs1),
                            .reads_rs2_o(fd_rs2), .is_branch_o(fd_br), .is_mem_o(fd_mem));
   inst_class_dec u_dec_x  (.opcode_i(inst_x[6:0]), .writes_rd_o(x_wr), .reads_rs1_o(x_rs1),
                            .reads_rs2_o(x_rs2), .is_branch_o(x_br), .is_mem_o(x_mem));
   inst_class_dec u_dec_mw (.opcode_i(inst_mw[6:0]), .writes_rd_o(mw_wr), .reads_rs1_o(mw_rs1),
                            .reads_rs2_o(mw_rs2), .is_branch_o(mw_br), .is_mem_o(mw_mem));

   logic unused_ok;
   assign unused_ok = ^{inst_fd[30:25], inst_fd[14:7], inst_x[31:25], inst_x[11:7],
                        inst_mw[31:12], fd_wr, fd_mem, x_wr, x_mem, mw_rs1, mw_rs2, mw_br};

   // Forwarding: MW must really write a non-x0 register that the consumer reads.
   logic       mw_fwd;
   logic [4:0] mw_rd;
   assign mw_rd  = inst_mw[11:7];
   assign mw_fwd = mw_wr && (mw_rd != 5'd0);

   assign wb2d_a  = mw_fwd && fd_rs1 && (inst_fd[19:15] == mw_rd);
   assign wb2d_b  = mw_fwd && fd_rs2 && (inst_fd[24:20] == mw_rd);
   assign asel[1] = mw_fwd && x_rs1 && (inst_x[19:15] == mw_rd);
   assign bsel[1] = mw_fwd && x_rs2 && (inst_x[24:20] == mw_rd);
   assign asel[0] = inst_x[6:0] inside {OPC_AUIPC, OPC_JAL, OPC_BR};
   assign bsel[0] = (inst_x[6:0] != OPC_R);
   assign brun    = x_br && (inst_x[14:13] == 2'b11);

   logic br_taken;
   always_comb begin
      br_taken = 1'b0;
      case (inst_x[14:12])
         3'b000:         br_taken = breq;
         3'b001:         br_taken = !breq;
         3'b100, 3'b110: br_taken = brlt;
         3'b101, 3'b111: br_taken = !brlt;
         default:        br_taken = 1'b0;
      endcase
   end

   logic fd_pred, x_jalr, mispred, recover, mem_busy;
   assign fd_pred  = (inst_fd[6:0] == OPC_JAL) || (PREDICT_BACKWARD && fd_br && inst_fd[31]);
   assign x_jalr   = (inst_x[6:0] == OPC_JALR);
   assign mispred  = x_br && (br_taken != pred_x_q);
   assign recover  = x_jalr || mispred;
   assign mem_busy = mw_mem && !dmem_ack;
   // While stalled, behaviour continues from the state that was interrupted.
   assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

   logic [1:0] pc_sel_c;
   logic       stall_c, flush_fd_c, flush_x_c, inc_flush, inc_mispred;

   always_comb begin
      state_d     = state_q;
      ret_d       = ret_q;
      rcnt_d      = rcnt_q;
      pred_x_d    = pred_x_q;
      pc_sel_c    = PC_PLUS4;
      stall_c     = 1'b0;
      flush_fd_c  = 1'b0;
      flush_x_c   = 1'b0;
      inc_flush   = 1'b0;
      inc_mispred = 1'b0;
      if (mem_busy) begin
         stall_c = 1'b1;
         state_d = ST_MEM_WAIT;
         ret_d   = eff_state;
      end else begin
         state_d = eff_state;
         if (recover) begin
            pc_sel_c    = (x_jalr || br_taken) ? PC_ALU : PC_X_PLUS4;
            flush_fd_c  = 1'b1;
            flush_x_c   = 1'b1;
            inc_flush   = 1'b1;
            inc_mispred = mispred;
            rcnt_d      = RCNT_INIT;
            state_d     = (FETCH_LAT > 1) ? ST_REDIRECT : ST_RUN;
         end else if (eff_state == ST_REDIRECT) begin
            // The recovery cycle itself was the first of FETCH_LAT bubbles.
            flush_fd_c = 1'b1;
            if (rcnt_q > 3'd1) begin
               rcnt_d = rcnt_q - 3'd1;
            end else begin
               rcnt_d  = '0;
               state_d = ST_RUN;
            end
         end else if (fd_pred) begin
            pc_sel_c = PC_FD_TGT;
         end
         pred_x_d = fd_pred && !flush_fd_c;
      end
   end

   assign pc_sel   = rst_n ? pc_sel_c : PC_PLUS4;
   assign stall    = rst_n && stall_c;
   assign flush_fd = rst_n && flush_fd_c;
   assign flush_x  = rst_n && flush_x_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         ret_q         <= ST_RUN;
         pred_x_q      <= 1'b0;
         rcnt_q        <= '0;
         cnt_stall_q   <= '0;
         cnt_flush_q   <= '0;
         cnt_mispred_q <= '0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         pred_x_q <= pred_x_d;
         rcnt_q   <= rcnt_d;
         if (stall_c && (cnt_stall_q != '1))       cnt_stall_q   <= cnt_stall_q + 1'b1;
         if (inc_flush && (cnt_flush_q != '1))     cnt_flush_q   <= cnt_flush_q + 1'b1;
         if (inc_mispred && (cnt_mispred_q != '1)) cnt_mispred_q <= cnt_mispred_q + 1'b1;
      end
   end

   assign cnt_stall   = cnt_stall_q;
   assign cnt_flush   = cnt_flush_q;
   assign cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with constant
// expectations plus a randomized run against a bubble-count reference model.
module tb_hazard_ctrl;

   localparam int FL = 2;
   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] ADDI_X0  = 32'h00100013;
   localparam logic [31:0] ADDI_X5  = 32'h00100293;
   localparam logic [31:0] ADD1_00  = 32'h000000B3;
   localparam logic [31:0] ADD1_55  = 32'h005280B3;
   localparam logic [31:0] ADD6_55  = 32'h00528333;
   localparam logic [31:0] LUI1     = 32'h000280B7;
   localparam logic [31:0] AUIPC0   = 32'h00028017;
   localparam logic [31:0] BEQ      = 32'h00000063;
   localparam logic [31:0] BINV     = 32'h00002063;
   localparam logic [31:0] BGE      = 32'h00005063;
   localparam logic [31:0] BLTU     = 32'h00006063;
   localparam logic [31:0] BNEB     = 32'h80001063;
   localparam logic [31:0] JAL      = 32'h0000006F;
   localparam logic [31:0] JALR     = 32'h00008067;
   localparam logic [31:0] LW       = 32'h00002003;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] inst_fd = NOP, inst_x = NOP, inst_mw = NOP;
   logic        breq = 1'b0, brlt = 1'b0, dmem_ack = 1'b1;
   logic [1:0]  pc_sel, asel, bsel;
   logic        stall, flush_fd, flush_x, brun, wb2d_a, wb2d_b;
   logic [31:0] cnt_stall, cnt_flush, cnt_mispred;
   logic [1:0]  s_pc_sel, s_asel, s_bsel;
   logic        s_stall, s_flush_fd, s_flush_x, s_brun, s_wb2d_a, s_wb2d_b;
   logic [3:0]  s_cnt_stall, s_cnt_flush, s_cnt_mispred;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.FETCH_LAT(FL), .PREDICT_BACKWARD(1'b1), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .inst_fd(inst_fd), .inst_x(inst_x), .inst_mw(inst_mw),
      .breq(breq), .brlt(brlt), .dmem_ack(dmem_ack), .pc_sel(pc_sel), .stall(stall),
      .flush_fd(flush_fd), .flush_x(flush_x), .brun(brun), .asel(asel), .bsel(bsel),
      .wb2d_a(wb2d_a), .wb2d_b(wb2d_b), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush),
      .cnt_mispred(cnt_mispred));

   hazard_ctrl #(.FETCH_LAT(FL), .PREDICT_BACKWARD(1'b1), .CNT_W(4)) u_sat (
      .clk(clk), .rst_n(rst_n), .inst_fd(inst_fd), .inst_x(inst_x), .inst_mw(inst_mw),
      .breq(breq), .brlt(brlt), .dmem_ack(dmem_ack), .pc_sel(s_pc_sel), .stall(s_stall),
      .flush_fd(s_flush_fd), .flush_x(s_flush_x), .brun(s_brun), .asel(s_asel), .bsel(s_bsel),
      .wb2d_a(s_wb2d_a), .wb2d_b(s_wb2d_b), .cnt_stall(s_cnt_stall), .cnt_flush(s_cnt_flush),
      .cnt_mispred(s_cnt_mispred));

   // Reference model: bubbles still owed after a redirect, prediction carried
   // into X, and event totals.
   bit m_pred, n_pred, pending;
   int m_left, n_left, m_cs, n_cs, m_cf, n_cf, m_cm, n_cm;
   logic [1:0] e_pc, e_asel, e_bsel;
   logic       e_stall, e_ffd, e_fx, e_brun, e_wa, e_wb;

   function automatic bit f_writes(input logic [6:0] op);
      return op inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17};
   endfunction
   function automatic bit f_rd1(input logic [6:0] op);
      return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
   endfunction
   function automatic bit f_rd2(input logic [6:0] op);
      return op inside {7'h33, 7'h23, 7'h63};
   endfunction
   function automatic bit f_taken(input logic [2:0] f3, input logic eq, input logic lt);
      case (f3)
         3'd0: return eq;
         3'd1: return !eq;
         3'd4, 3'd6: return lt;
         3'd5, 3'd7: return !lt;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_eval();
      logic [6:0] ofd, ox, omw;
      logic [4:0] rd;
      bit fw, isb, t, fdp;
      ofd = inst_fd[6:0]; ox = inst_x[6:0]; omw = inst_mw[6:0]; rd = inst_mw[11:7];
      fw = f_writes(omw) && (rd != 5'd0);
      e_wa   = fw && f_rd1(ofd) && (inst_fd[19:15] == rd);
      e_wb   = fw && f_rd2(ofd) && (inst_fd[24:20] == rd);
      e_asel = {fw && f_rd1(ox) && (inst_x[19:15] == rd), ox inside {7'h17, 7'h6F, 7'h63}};
      e_bsel = {fw && f_rd2(ox) && (inst_x[24:20] == rd), ox != 7'h33};
      e_brun = (ox == 7'h63) && (inst_x[14:12] >= 3'd6);
      n_pred = m_pred; n_left = m_left; n_cs = m_cs; n_cf = m_cf; n_cm = m_cm;
      e_stall = 1'b0; e_ffd = 1'b0; e_fx = 1'b0; e_pc = 2'd2;
      if ((omw == 7'h03 || omw == 7'h23) && !dmem_ack) begin
         e_stall = 1'b1;
         n_cs = m_cs + 1;
      end else begin
         isb = (ox == 7'h63);
         t   = f_taken(inst_x[14:12], breq, brlt);
         fdp = (ofd == 7'h6F) || (ofd == 7'h63 && inst_fd[31]);
         if (ox == 7'h67 || (isb && t != m_pred)) begin
            e_pc = (ox == 7'h67 || t) ? 2'd1 : 2'd3;
            e_ffd = 1'b1; e_fx = 1'b1;
            n_cf = m_cf + 1;
            if (isb) n_cm = m_cm + 1;
            n_left = FL - 1;
         end else if (m_left > 0) begin
            e_ffd = 1'b1;
            n_left = m_left - 1;
         end else if (fdp) begin
            e_pc = 2'd0;
         end
         n_pred = fdp && !e_ffd;
      end
   endtask

   task automatic apply(input logic [31:0] fd, x, mw, input logic eq, lt, ack);
      if (pending) begin
         @(posedge clk);
         m_pred = n_pred; m_left = n_left; m_cs = n_cs; m_cf = n_cf; m_cm = n_cm;
      end
      @(negedge clk);
      inst_fd = fd; inst_x = x; inst_mw = mw; breq = eq; brlt = lt; dmem_ack = ack;
      #1;
      model_eval();
      pending = 1'b1;
   endtask

   task automatic model_clear();
      pending = 1'b0; m_pred = 1'b0; m_left = 0; m_cs = 0; m_cf = 0; m_cm = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      inst_fd = NOP; inst_x = NOP; inst_mw = NOP; breq = 1'b0; brlt = 1'b0; dmem_ack = 1'b1;
      #2;
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      inst_fd = JAL; inst_x = JALR; inst_mw = LW; dmem_ack = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
      checks++; if (pc_sel !== 2'd2) begin errors++; $display("FAIL reset_pc_sel got=%0d exp=2", pc_sel); end
      checks++; if ({flush_fd, flush_x} !== 2'b00) begin errors++; $display("FAIL reset_flush got=%b exp=00", {flush_fd, flush_x}); end
      checks++; if ({cnt_stall, cnt_flush, cnt_mispred} !== 96'd0) begin errors++; $display("FAIL reset_counters got=%h exp=0", {cnt_stall, cnt_flush, cnt_mispred}); end
      checks++; if (s_cnt_stall !== 4'd0) begin errors++; $display("FAIL reset_sat_cnt got=%h exp=0", s_cnt_stall); end
      inst_fd = NOP; inst_x = NOP; inst_mw = NOP; dmem_ack = 1'b1;
      #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   task automatic test_forwarding();
      do_reset();
      apply(ADD1_00, NOP, ADDI_X0, 0, 0, 1);
      checks++; if ({wb2d_a, wb2d_b} !== 2'b00) begin errors++; $display("FAIL fwd_x0 got=%b exp=00", {wb2d_a, wb2d_b}); end
      apply(ADD1_55, ADD6_55, ADDI_X5, 0, 0, 1);
      checks++; if ({wb2d_a, wb2d_b} !== 2'b11) begin errors++; $display("FAIL fwd_fd got=%b exp=11", {wb2d_a, wb2d_b}); end
      checks++; if (asel !== 2'b10) begin errors++; $display("FAIL fwd_asel got=%b exp=10", asel); end
      checks++; if (bsel !== 2'b10) begin errors++; $display("FAIL fwd_bsel got=%b exp=10", bsel); end
      apply(LUI1, AUIPC0, ADDI_X5, 0, 0, 1);
      checks++; if (wb2d_a !== 1'b0) begin errors++; $display("FAIL fwd_nonreader got=%b exp=0", wb2d_a); end
      checks++; if ({asel, bsel} !== 4'b0101) begin errors++; $display("FAIL fwd_auipc_sel got=%b exp=0101", {asel, bsel}); end
      apply(NOP, BLTU, NOP, 0, 0, 1);
      checks++; if (brun !== 1'b1) begin errors++; $display("FAIL brun_bltu got=%b exp=1", brun); end
      apply(NOP, BGE, NOP, 0, 1, 1);
      checks++; if (brun !== 1'b0) begin errors++; $display("FAIL brun_bge got=%b exp=0", brun); end
   endtask

   task automatic test_branch_recovery();
      do_reset();
      apply(NOP, BINV, NOP, 1, 1, 1);
      checks++; if ({pc_sel, flush_fd} !== 3'b100) begin errors++; $display("FAIL br_invalid got=%b exp=100", {pc_sel, flush_fd}); end
      apply(NOP, BEQ, NOP, 1, 0, 1);
      checks++; if (pc_sel !== 2'd1) begin errors++; $display("FAIL br_taken_pc got=%0d exp=1", pc_sel); end
      checks++; if ({flush_fd, flush_x} !== 2'b11) begin errors++; $display("FAIL br_taken_flush got=%b exp=11", {flush_fd, flush_x}); end
      apply(NOP, NOP, NOP, 0, 0, 1);
      checks++; if ({flush_fd, flush_x} !== 2'b10) begin errors++; $display("FAIL br_bubble2 got=%b exp=10", {flush_fd, flush_x}); end
      checks++; if ({cnt_flush, cnt_mispred} !== {32'd1, 32'd1}) begin errors++; $display("FAIL br_counters got=%0d/%0d exp=1/1", cnt_flush, cnt_mispred); end
      apply(NOP, NOP, NOP, 0, 0, 1);
      checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL br_bubble_end got=%b exp=0", flush_fd); end
   endtask

   task automatic test_predict();
      do_reset();
      apply(JAL, NOP, NOP, 0, 0, 1);
      checks++; if (pc_sel !== 2'd0) begin errors++; $display("FAIL pred_jal got=%0d exp=0", pc_sel); end
      apply(BNEB, NOP, NOP, 0, 0, 1);
      checks++; if (pc_sel !== 2'd0) begin errors++; $display("FAIL pred_bne_back got=%0d exp=0", pc_sel); end
      apply(NOP, BNEB, NOP, 0, 0, 1);
      checks++; if ({pc_sel, flush_fd} !== 3'b100) begin errors++; $display("FAIL pred_correct got=%b exp=100", {pc_sel, flush_fd}); end
      apply(BNEB, NOP, NOP, 0, 0, 1);
      apply(NOP, BNEB, NOP, 1, 0, 1);
      checks++; if ({pc_sel, flush_fd} !== 3'b111) begin errors++; $display("FAIL pred_wrong got=%b exp=111", {pc_sel, flush_fd}); end
      apply(NOP, NOP, NOP, 0, 0, 1);
      checks++; if ({cnt_flush, cnt_mispred} !== {32'd1, 32'd1}) begin errors++; $display("FAIL pred_counters got=%0d/%0d exp=1/1", cnt_flush, cnt_mispred); end
   endtask

   task automatic test_mem_wait();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         apply(NOP, JALR, LW, 0, 0, 0);
         checks++; if ({stall, flush_fd, flush_x} !== 3'b100) begin errors++; $display("FAIL mem_stall%0d got=%b exp=100", i, {stall, flush_fd, flush_x}); end
      end
      apply(NOP, JALR, LW, 0, 0, 1);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mem_release got=%b exp=0", stall); end
      checks++; if ({pc_sel, flush_fd} !== 3'b011) begin errors++; $display("FAIL mem_jalr_after got=%b exp=011", {pc_sel, flush_fd}); end
      checks++; if (cnt_stall !== 32'd3) begin errors++; $display("FAIL mem_cnt_stall got=%0d exp=3", cnt_stall); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      apply(NOP, BEQ, NOP, 1, 0, 1);
      apply(NOP, NOP, LW, 0, 0, 0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall got=%b exp=1", stall); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if ({stall, flush_fd, flush_x, pc_sel} !== 5'b00010) begin errors++; $display("FAIL mid_reset_outs got=%b exp=00010", {stall, flush_fd, flush_x, pc_sel}); end
      checks++; if ({cnt_stall, cnt_flush, cnt_mispred} !== 96'd0) begin errors++; $display("FAIL mid_reset_cnt got=%h exp=0", {cnt_stall, cnt_flush, cnt_mispred}); end
      inst_mw = NOP; dmem_ack = 1'b1;
      rst_n = 1'b1;
      model_clear();
      apply(NOP, NOP, NOP, 0, 0, 1);
      checks++; if ({stall, flush_fd} !== 2'b00) begin errors++; $display("FAIL mid_after_run got=%b exp=00", {stall, flush_fd}); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) apply(NOP, NOP, LW, 0, 0, 0);
      apply(NOP, NOP, NOP, 0, 0, 1);
      checks++; if (s_cnt_stall !== 4'hF) begin errors++; $display("FAIL sat_cnt_stall got=%h exp=f", s_cnt_stall); end
      checks++; if (cnt_stall !== 32'd20) begin errors++; $display("FAIL wide_cnt_stall got=%0d exp=20", cnt_stall); end
   endtask

   function automatic logic [31:0] rnd_inst();
      logic [6:0] op;
      case ($urandom_range(0, 10))
         0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h23;
         4: op = 7'h63;  5: op = 7'h6F;  6: op = 7'h67;  7: op = 7'h37;
         8: op = 7'h17;  9: op = 7'h73;  default: op = 7'h00;
      endcase
      return {1'($urandom), 6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 5'($urandom_range(0, 3)), op};
   endfunction

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         apply(rnd_inst(), rnd_inst(), rnd_inst(), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0));
         checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd%0d stall got=%b exp=%b", i, stall, e_stall); end
         if (!e_stall) begin
            checks++; if (pc_sel !== e_pc) begin errors++; $display("FAIL rnd%0d pc_sel got=%0d exp=%0d", i, pc_sel, e_pc); end
         end
         checks++; if ({flush_fd, flush_x} !== {e_ffd, e_fx}) begin errors++; $display("FAIL rnd%0d flush got=%b exp=%b", i, {flush_fd, flush_x}, {e_ffd, e_fx}); end
         checks++; if ({asel, bsel, brun} !== {e_asel, e_bsel, e_brun}) begin errors++; $display("FAIL rnd%0d sel got=%b exp=%b", i, {asel, bsel, brun}, {e_asel, e_bsel, e_brun}); end
         checks++; if ({wb2d_a, wb2d_b} !== {e_wa, e_wb}) begin errors++; $display("FAIL rnd%0d wb2d got=%b exp=%b", i, {wb2d_a, wb2d_b}, {e_wa, e_wb}); end
         checks++; if (cnt_stall !== 32'(m_cs)) begin errors++; $display("FAIL rnd%0d cnt_stall got=%0d exp=%0d", i, cnt_stall, m_cs); end
         checks++; if (cnt_flush !== 32'(m_cf)) begin errors++; $display("FAIL rnd%0d cnt_flush got=%0d exp=%0d", i, cnt_flush, m_cf); end
         checks++; if (cnt_mispred !== 32'(m_cm)) begin errors++; $display("FAIL rnd%0d cnt_mispred got=%0d exp=%0d", i, cnt_mispred, m_cm); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      model_clear();
      test_reset();
      test_forwarding();
      test_branch_recovery();
      test_predict();
      test_mem_wait();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
